psum_drain: RTL and testbench
=============================

// Module: psum_drain
// PURPOSE
// Consumer end of a PE row: captures the psum stream leaving the last PE, binarizes each psum against a
// threshold and packs the resulting activation bits into words for the next layer's input buffer.
// Sits directly after a PE row. Tracks which cycles carry valid psums by delaying the window tags
// issued to the row. Buffers words in a FIFO with valid/ready output and back-pressures the window feeder.
// PARAMETERS
// WIDTH       14  psum width, two's complement; matches the row's psum width
// LATENCY     11  cycles from window issue to valid psum at psum_in (one per PE in the row)
// PACK_WIDTH  27  activation bits per output word
// DEPTH       16  output FIFO entries; must be >= LATENCY+2
// PORTS
// clk_in          input   1                         clock, rising edge
// rst_in          input   1                         reset, synchronous, active-high
// win_valid_in    input   1                         a window is presented to the row this cycle
// win_last_in     input   1                         that window is the last of its frame (qualified by win_valid_in)
// psum_in         input   WIDTH                     psum_out of the row's last PE
// threshold_in    input   WIDTH                     signed binarization threshold, sampled at capture
// stall_out       output  1                         feeder must not assert win_valid_in while high
// word_valid_out  output  1                         FIFO head valid
// word_ready_in   input   1                         sink accepts head when both valid and ready
// word_data_out   output  PACK_WIDTH                packed bits; bit 0 = first window of the word
// word_count_out  output  $clog2(PACK_WIDTH+1)      number of valid bits in word_data_out (1..PACK_WIDTH)
// word_last_out   output  1                         word closes a frame
// overflow_out    output  1                         sticky: push attempted while FIFO full
// BEHAVIOUR
// - Reset: all outputs 0; tag pipeline, packer and FIFO cleared. Mid-operation reset discards in-flight psums
//   and any partial word. No word is emitted for them.
// - Tag pipeline: LATENCY-stage shift register of {valid,last}. Stage 0 loads {win_valid_in, win_valid_in&win_last_in}.
//   Capture occurs in the cycle the final stage is valid, i.e. psum_in is sampled exactly LATENCY cycles after issue.
// - Binarize: bit = ($signed(psum_in) >= $signed(threshold_in)). Equality gives 1. Compare is full WIDTH with no saturation.
// - Packer: the bit is written at index pack_cnt and pack_cnt increments. A push of {data,count,last} happens on the
//   capture that fills bit PACK_WIDTH-1 or that carries the last tag, whichever comes first.
//   Bits above count are 0. On push, the packer clears and pack_cnt becomes 0.
//   last with pack_cnt at PACK_WIDTH-1 gives one full word with last=1, not an extra empty word.
// - FIFO: one push per capture maximum. Pop when word_valid_out & word_ready_in. Push and pop in the same cycle
//   are both honoured, including when the FIFO is full. The head is stable while valid and not ready.
// - Push while full without a same-cycle pop: the word is dropped, overflow_out is set until reset, and the FIFO
//   is otherwise unchanged.
// - stall_out = (fifo_count >= DEPTH-LATENCY-1), registered from the count. This guarantees that windows already
//   in flight can never overflow the FIFO. Ignoring stall_out is a protocol violation reported by overflow_out.
// - Throughput: one window per cycle sustained while the sink is always ready. No bubbles when words end.
// - Output latency: a word becomes visible on word_valid_out the cycle after its final capture. Total latency is
//   LATENCY+1 cycles from the issue of that window.
// STRUCTURE
// - Shared package: WIDTH/PACK_WIDTH defaults, count width localparam, typedef drain_word_t {data,count,last}.
// - Sub-module drain_fifo: synchronous FIFO of drain_word_t with DEPTH entries. It exposes count, full, empty and
//   overflow. The tag pipeline, binarizer and packer live in this module.
// TESTING
// 1 27 windows back-to-back, psum=+5, threshold=0, ready=1 -> one word, data=27'h7FFFFFF, count=27, last=0,
//   valid at cycle LATENCY+27.
// 2 Alternating psum -3/+3, threshold=0, last on the 10th window -> data=10'b1010101010 (bit0=0), count=10, last=1.
// 3 psum==threshold==-7 -> bit=1; psum=-8 with threshold=-7 -> bit=0 (signed compare check).
// 4 Sink ready=0, continuous windows -> stall_out rises when fifo_count reaches 4. Feeder obeys stall_out;
//   FIFO peaks at <=DEPTH and overflow_out=0. Then ready=1 drains the words in order.
// 5 Last on the 27th window -> exactly one word with count=27, last=1. The next window starts at bit 0.
// 6 rst_in pulse 5 cycles after issuing 8 windows -> no word is ever emitted. All outputs are 0 the cycle after reset.

Source files
------------

// File: rtl/psum_drain_pkg.sv
// Shared types and constants for the psum drain: output word layout and the binarizer.
package psum_drain_pkg;

    localparam int unsigned WIDTH       = 14;
    localparam int unsigned PACK_WIDTH  = 27;
    localparam int unsigned COUNT_WIDTH = $clog2(PACK_WIDTH + 1);

    // One packed activation word as it travels through the output FIFO.
    typedef struct packed {
        logic [PACK_WIDTH-1:0]  data;
        logic [COUNT_WIDTH-1:0] count;
        logic                   last;
    } drain_word_t;

    // Activation bit: psum at or above threshold, both two's complement, full width.
    function automatic logic binarize(logic [WIDTH-1:0] psum, logic [WIDTH-1:0] threshold);
        return $signed(psum) >= $signed(threshold);
    endfunction

endpackage

// File: rtl/psum_drain_if.sv
// Window-feeder and word-sink signals of the psum drain.
interface psum_drain_if;

    logic                                  win_valid_in;
    logic                                  win_last_in;
    logic [psum_drain_pkg::WIDTH-1:0]       psum_in;
    logic [psum_drain_pkg::WIDTH-1:0]       threshold_in;
    logic                                  stall_out;
    logic                                  word_valid_out;
    logic                                  word_ready_in;
    logic [psum_drain_pkg::PACK_WIDTH-1:0]  word_data_out;
    logic [psum_drain_pkg::COUNT_WIDTH-1:0] word_count_out;
    logic                                  word_last_out;
    logic                                  overflow_out;

    // Feeder/sink side.
    modport master (
        output win_valid_in, win_last_in, psum_in, threshold_in, word_ready_in,
        input  stall_out, word_valid_out, word_data_out, word_count_out, word_last_out,
               overflow_out
    );

    // Drain side.
    modport slave (
        input  win_valid_in, win_last_in, psum_in, threshold_in, word_ready_in,
        output stall_out, word_valid_out, word_data_out, word_count_out, word_last_out,
               overflow_out
    );

endinterface

// File: rtl/drain_fifo.sv
// Synchronous FIFO of packed activation words with a sticky overflow flag.
module drain_fifo
    import psum_drain_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  drain_word_t                push_word_i,
    input  logic                       pop_i,
    output drain_word_t                head_word_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       overflow_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    drain_word_t      mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             do_push, do_pop;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    // Head reads as zero while empty so the outputs are clean after reset.
    assign head_word_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Next-state: a pop frees the slot a same-cycle push needs, so full+pop+push is accepted.
    always_comb begin
        do_pop     = pop_i && !empty_o;
        do_push    = push_i && (!full_o || do_pop);
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (push_i && full_o && !do_pop);
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer, count and overflow registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array; contents need no reset since empty masks the head.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_word_i;
        end
    end

endmodule

// File: rtl/psum_drain.sv
// Drain at the end of a PE row: tracks valid psum cycles via delayed window tags, binarizes each
// captured psum against the threshold, packs the bits into words and queues them for the sink.
module psum_drain
    import psum_drain_pkg::*;
#(
    parameter int unsigned LATENCY = 11,
    // Must be at least LATENCY+2 so in-flight windows always fit after stall rises.
    parameter int unsigned DEPTH   = 16
) (
    input  logic       clk_in,
    input  logic       rst_in,
    psum_drain_if.slave bus
);

    localparam int unsigned FIFO_CNT_W = $clog2(DEPTH + 1);
    localparam logic [FIFO_CNT_W-1:0] STALL_AT = FIFO_CNT_W'(DEPTH - LATENCY - 1);

    logic [LATENCY-1:0]     tag_valid_q, tag_valid_d;
    logic [LATENCY-1:0]     tag_last_q, tag_last_d;
    logic [PACK_WIDTH-1:0]  pack_data_q, pack_data_d, merged_data;
    logic [COUNT_WIDTH-1:0] pack_cnt_q, pack_cnt_d;
    logic                   capture, capture_last, act_bit, word_done;
    drain_word_t            push_word, head_word;
    logic [FIFO_CNT_W-1:0]  fifo_count;
    logic                   fifo_full, fifo_empty, fifo_overflow, fifo_pop;
    logic                   stall_q;
    logic                   unused_full;

    // Tag pipeline shift: stage 0 takes the window issued this cycle, last only if valid.
    always_comb begin
        tag_valid_d    = '0;
        tag_last_d     = '0;
        tag_valid_d[0] = bus.win_valid_in;
        tag_last_d[0]  = bus.win_valid_in & bus.win_last_in;
        for (int i = 1; i < LATENCY; i++) begin
            tag_valid_d[i] = tag_valid_q[i-1];
            tag_last_d[i]  = tag_last_q[i-1];
        end
    end

    // Packer: merge the captured bit and close the word on the final bit or a frame end.
    always_comb begin
        capture      = tag_valid_q[LATENCY-1];
        capture_last = tag_last_q[LATENCY-1];
        act_bit      = binarize(bus.psum_in, bus.threshold_in);
        merged_data  = pack_data_q;
        merged_data[pack_cnt_q] = act_bit;
        word_done = capture && (capture_last || (pack_cnt_q == COUNT_WIDTH'(PACK_WIDTH - 1)));
        push_word.data  = merged_data;
        push_word.count = pack_cnt_q + 1'b1;
        push_word.last  = capture_last;
        pack_data_d = pack_data_q;
        pack_cnt_d  = pack_cnt_q;
        if (word_done) begin
            pack_data_d = '0;
            pack_cnt_d  = '0;
        end else if (capture) begin
            pack_data_d = merged_data;
            pack_cnt_d  = pack_cnt_q + 1'b1;
        end
    end

    // Tag, packer and stall registers; reset drops in-flight windows and any partial word.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tag_valid_q <= '0;
            tag_last_q  <= '0;
            pack_data_q <= '0;
            pack_cnt_q  <= '0;
            stall_q     <= 1'b0;
        end else begin
            tag_valid_q <= tag_valid_d;
            tag_last_q  <= tag_last_d;
            pack_data_q <= pack_data_d;
            pack_cnt_q  <= pack_cnt_d;
            stall_q     <= (fifo_count >= STALL_AT);
        end
    end

    assign fifo_pop = !fifo_empty && bus.word_ready_in;

    drain_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_in),
        .rst_i       (rst_in),
        .push_i      (word_done),
        .push_word_i (push_word),
        .pop_i       (fifo_pop),
        .head_word_o (head_word),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .overflow_o  (fifo_overflow)
    );

    // Full is implied by the overflow flag here; the stall threshold keeps us clear of it.
    assign unused_full = fifo_full;

    assign bus.stall_out      = stall_q;
    assign bus.word_valid_out = !fifo_empty;
    assign bus.word_data_out  = head_word.data;
    assign bus.word_count_out = head_word.count;
    assign bus.word_last_out  = head_word.last;
    assign bus.overflow_out   = fifo_overflow;

endmodule

// File: tb/tb_psum_drain.sv
// Scoreboard bench for psum_drain: stimulus feeds a bit-list reference model that queues expected
// words with the cycle they become visible; a negedge monitor checks the DUT against that queue.
module tb_psum_drain;
    import psum_drain_pkg::*;

    localparam int unsigned LATENCY  = 11;
    localparam int unsigned DEPTH    = 16;
    localparam int          STALL_AT = DEPTH - LATENCY - 1;

    typedef struct {
        int               cyc;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] t;
    } sched_t;

    typedef struct {
        logic [PACK_WIDTH-1:0] data;
        int                    count;
        bit                    last;
        int                    vis;
    } exp_t;

    logic clk;
    logic rst_in;

    psum_drain_if bus();

    psum_drain #(
        .LATENCY (LATENCY),
        .DEPTH   (DEPTH)
    ) dut (
        .clk_in (clk),
        .rst_in (rst_in),
        .bus    (bus)
    );

    sched_t sched_q[$];
    exp_t   exp_q[$];
    bit     bits_q[$];
    int     cyc         = 0;
    int     vectors     = 0;
    int     miscompares = 0;
    int     ovf_vis     = -1;
    bit     cap_mode    = 0;
    int     occ_prev    = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference: collect bits per window; a word closes at 27 bits or on a frame's last window,
    // and is visible LATENCY+1 cycles after that window was issued.
    task automatic model_issue(input bit last, input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] t);
        int   ps;
        int   ts;
        exp_t e;
        ps = $signed(p);
        ts = $signed(t);
        bits_q.push_back(ps >= ts);
        if (last || bits_q.size() == PACK_WIDTH) begin
            e.data = '0;
            foreach (bits_q[i]) e.data[i] = bits_q[i];
            e.count = bits_q.size();
            e.last  = last;
            e.vis   = cyc + LATENCY + 1;
            bits_q.delete();
            // With no sink activity the FIFO holds exactly the queued words; extras are dropped.
            if (cap_mode && exp_q.size() >= DEPTH) begin
                if (ovf_vis < 0) ovf_vis = e.vis;
            end else begin
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic drive(input bit v, input bit l, input logic [WIDTH-1:0] p,
                         input logic [WIDTH-1:0] t, input bit rdy);
        bus.win_valid_in  = v;
        bus.win_last_in   = l;
        bus.word_ready_in = rdy;
        if (v) begin
            sched_q.push_back('{cyc: cyc + LATENCY, p: p, t: t});
            model_issue(l, p, t);
        end
        if (sched_q.size() > 0 && sched_q[0].cyc == cyc) begin
            bus.psum_in      = sched_q[0].p;
            bus.threshold_in = sched_q[0].t;
            void'(sched_q.pop_front());
        end else begin
            bus.psum_in      = WIDTH'($urandom);
            bus.threshold_in = WIDTH'($urandom);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, ($urandom_range(1) == 1), WIDTH'($urandom), WIDTH'($urandom), rdy);
        end
    endtask

    task automatic do_reset(input int n);
        rst_in           = 1'b1;
        bus.win_valid_in = 1'b0;
        sched_q.delete();
        bits_q.delete();
        exp_q.delete();
        ovf_vis  = -1;
        cap_mode = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        rst_in = 1'b0;
    endtask

    task automatic reset_checks();
        check("rst_valid", 64'(bus.word_valid_out), 64'(0));
        check("rst_data", 64'(bus.word_data_out), 64'(0));
        check("rst_count", 64'(bus.word_count_out), 64'(0));
        check("rst_last", 64'(bus.word_last_out), 64'(0));
        check("rst_stall", 64'(bus.stall_out), 64'(0));
        check("rst_overflow", 64'(bus.overflow_out), 64'(0));
    endtask

    // Monitor: occupancy, stall, overflow and the head word against the scoreboard.
    initial begin
        int occ;
        forever begin
            @(negedge clk);
            if (rst_in !== 1'b0) begin
                occ_prev = 0;
                continue;
            end
            occ = 0;
            for (int i = 0; i < exp_q.size(); i++) begin
                if (exp_q[i].vis <= cyc) occ++;
                else break;
            end
            check("valid", 64'(bus.word_valid_out), 64'(occ > 0));
            check("stall", 64'(bus.stall_out), 64'(occ_prev >= STALL_AT));
            check("overflow", 64'(bus.overflow_out), 64'(ovf_vis >= 0 && cyc >= ovf_vis));
            if (bus.word_valid_out === 1'b1 && bus.word_ready_in === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("spurious_word", 64'(1), 64'(0));
                end else begin
                    check("word_data", 64'(bus.word_data_out), 64'(exp_q[0].data));
                    check("word_count", 64'(bus.word_count_out), 64'(exp_q[0].count));
                    check("word_last", 64'(bus.word_last_out), 64'(exp_q[0].last));
                    void'(exp_q.pop_front());
                end
            end
            occ_prev = occ;
        end
    end

    initial begin
        int n;
        rst_in            = 1'b1;
        bus.win_valid_in  = 1'b0;
        bus.win_last_in   = 1'b0;
        bus.psum_in       = '0;
        bus.threshold_in  = '0;
        bus.word_ready_in = 1'b1;
        do_reset(3);
        reset_checks();

        // 27 positive psums against zero: one full word of ones, no frame end.
        for (int i = 0; i < 27; i++) drive(1'b1, 1'b0, WIDTH'(5), WIDTH'(0), 1'b1);
        idle(15, 1'b1);

        // Alternating -3/+3, frame ends on the 10th window.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, (i == 9), (i % 2 == 1) ? WIDTH'(3) : WIDTH'(-3), WIDTH'(0), 1'b1);
        end
        idle(15, 1'b1);

        // Signed compare boundary: equality gives 1, one below gives 0.
        drive(1'b1, 1'b0, WIDTH'(-7), WIDTH'(-7), 1'b1);
        drive(1'b1, 1'b1, WIDTH'(-8), WIDTH'(-7), 1'b1);
        idle(15, 1'b1);

        // Frame end on the 27th window, then a fresh word starting at bit 0.
        for (int i = 0; i < 27; i++) begin
            drive(1'b1, (i == 26), WIDTH'($urandom), WIDTH'($urandom), 1'b1);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, (i == 2), WIDTH'($urandom), WIDTH'($urandom), 1'b1);
        end
        idle(15, 1'b1);

        // Sink blocked, feeder obeys stall with one word per window; then drain in order.
        for (int i = 0; i < 60; i++) begin
            drive(!bus.stall_out, 1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'b0);
        end
        idle(40, 1'b1);

        // Randomized traffic with random sink back-pressure.
        for (int i = 0; i < 800; i++) begin
            drive(($urandom_range(3) != 0) && !bus.stall_out, ($urandom_range(7) == 0),
                  WIDTH'($urandom), WIDTH'($urandom), ($urandom_range(3) != 0));
        end
        idle(60, 1'b1);

        // Protocol violation: feeder ignores stall with a blocked sink, forcing overflow.
        cap_mode = 1;
        for (int i = 0; i < 30; i++) begin
            drive(1'b1, 1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'b0);
        end
        idle(15, 1'b0);
        do_reset(1);
        reset_checks();

        // Reset with windows in flight: nothing may ever come out.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, (i == 7), WIDTH'($urandom), WIDTH'($urandom), 1'b1);
        end
        idle(5, 1'b1);
        do_reset(1);
        reset_checks();
        idle(25, 1'b1);

        // Final drain with a bounded budget.
        n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            idle(1, 1'b1);
            n++;
        end
        check("drain_done", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
